// File: rtl/vp_pkg.sv
// Shared video-path types: matrix window controller FSM encoding and window border.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vp_pkg;

    typedef enum logic [1:0] {
        MWC_IDLE      = 2'd0,
        MWC_WAIT_LINE = 2'd1,
        MWC_ACTIVE    = 2'd2,
        MWC_DONE      = 2'd3
    } mwc_state_e;

    // A 3x3 window is complete once its right/bottom edge reaches index 2.
    localparam int WIN_BORDER = 2;

endpackage

// File: rtl/vp_delay_line.sv
// Fixed-depth register pipeline used to align sideband signals with window registers.
// Latency: DEPTH cycles, output is din delayed DEPTH clocks.
// Backpressure: none; shifts every cycle.
module vp_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] stage_q;
    logic [DEPTH-1:0][W-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/matrix_window_ctrl.sv
// 3x3 window sequencer: gates line-buffer shifts to in-frame pixels, tracks position, flags full windows.
// Latency: shift_en 0, read_de 1, win_* 2 cycles; error flags need MATRIX_WINDOW_CTRL_ERR_EN.
// Backpressure: none; the pixel stream cannot be stalled, surplus pixels are dropped.
module matrix_window_ctrl
    import vp_pkg::*;
#(
    parameter int IMG_HDISP = 1280,
    parameter int IMG_VDISP = 720,
    parameter int CW        = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pre_vs,
    input  logic          pre_de,
    output logic          shift_en,
    output logic          read_de,
    output logic          win_vs,
    output logic          win_de,
    output logic          win_valid,
    output logic [CW-1:0] win_col,
    output logic [CW-1:0] win_row,
    output logic          frame_start,
    output logic          frame_done,
    output logic          busy,
    output logic          err_len,
    output logic          err_short
);

    localparam logic [CW-1:0] COL_MAX  = '1;
    localparam logic [CW-1:0] VDISP_C  = CW'(IMG_VDISP);
    localparam logic [CW-1:0] BORDER_C = CW'(WIN_BORDER);

    mwc_state_e    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] row_next;
    logic          vs_prev_q;
    logic          frame_start_q, frame_start_d;
    logic          frame_done_q, frame_done_d;
    logic          read_de_q;
    logic          vs_rise;
    logic          line_end;

`ifdef MATRIX_WINDOW_CTRL_ERR_EN
    localparam logic [CW-1:0] HDISP_C = CW'(IMG_HDISP);
    logic          err_len_q, err_len_d;
    logic          err_short_q, err_short_d;
`endif

    assign vs_rise  = pre_vs & ~vs_prev_q;
    assign row_next = row_q + 1'b1;
    // A line closes on pre_de falling, or when the frame is cut short mid-line.
    assign line_end = (state_q == MWC_ACTIVE) && (!pre_de || !pre_vs);
    assign shift_en = pre_de && ((state_q == MWC_WAIT_LINE) || (state_q == MWC_ACTIVE));

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        case (state_q)
            MWC_IDLE: begin
                if (vs_rise) begin
                    state_d       = MWC_WAIT_LINE;
                    frame_start_d = 1'b1;
                    col_d         = '0;
                    row_d         = '0;
                end
            end
            MWC_WAIT_LINE: begin
                if (!pre_vs) begin
                    state_d      = MWC_IDLE;
                    frame_done_d = 1'b1;
                end else if (pre_de) begin
                    state_d = MWC_ACTIVE;
                    col_d   = {{(CW-1){1'b0}}, 1'b1};
                end
            end
            MWC_ACTIVE: begin
                if (line_end) begin
                    col_d = '0;
                    row_d = row_next;
                    if (!pre_vs) begin
                        state_d      = MWC_IDLE;
                        frame_done_d = 1'b1;
                    end else if (row_next == VDISP_C) begin
                        state_d      = MWC_DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = MWC_WAIT_LINE;
                    end
                end else if (col_q != COL_MAX) begin
                    col_d = col_q + 1'b1;
                end
            end
            MWC_DONE: begin
                if (!pre_vs) begin
                    state_d = MWC_IDLE;
                end
            end
            default: state_d = MWC_IDLE;
        endcase
    end

`ifdef MATRIX_WINDOW_CTRL_ERR_EN
    always_comb begin
        err_len_d   = err_len_q;
        err_short_d = err_short_q;
        if (state_q == MWC_IDLE && vs_rise) begin
            err_len_d   = 1'b0;
            err_short_d = 1'b0;
        end else if (state_q == MWC_WAIT_LINE && !pre_vs) begin
            err_short_d = 1'b1;
        end else if (line_end) begin
            if (col_q != HDISP_C) begin
                err_len_d = 1'b1;
            end
            if (!pre_vs && row_next < VDISP_C) begin
                err_short_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len_q   <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            err_len_q   <= err_len_d;
            err_short_q <= err_short_d;
        end
    end

    assign err_len   = err_len_q;
    assign err_short = err_short_q;
`else
    assign err_len   = 1'b0;
    assign err_short = 1'b0;
`endif

    // vs history resets high so a frame already in progress at reset release is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= MWC_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            vs_prev_q     <= 1'b1;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            read_de_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            vs_prev_q     <= pre_vs;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            read_de_q     <= shift_en;
        end
    end

    vp_delay_line #(
        .W     (2 + 2*CW),
        .DEPTH (2)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({pre_vs, shift_en, col_q, row_q}),
        .dout  ({win_vs, win_de, win_col, win_row})
    );

    assign read_de     = read_de_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign busy        = (state_q != MWC_IDLE);
    assign win_valid   = win_de && (win_col >= BORDER_C) && (win_row >= BORDER_C);

endmodule

// File: tb/tb_matrix_window_ctrl.sv
// Directed bench for matrix_window_ctrl on a 4x3 frame.
module tb_matrix_window_ctrl;

    localparam int CW = 12;
`ifdef MATRIX_WINDOW_CTRL_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pre_vs;
    logic          pre_de;
    logic          shift_en, read_de, win_vs, win_de, win_valid;
    logic [CW-1:0] win_col, win_row;
    logic          frame_start, frame_done, busy, err_len, err_short;

    int n_assert = 0;
    int n_fail   = 0;
    int fs_cnt   = 0;
    int fd_cnt   = 0;
    int wd_cnt   = 0;
    logic [CW-1:0] wv_col_q[$];
    logic [CW-1:0] wv_row_q[$];

    always #5 clk = ~clk;

    matrix_window_ctrl #(
        .IMG_HDISP (4),
        .IMG_VDISP (3),
        .CW        (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pre_vs      (pre_vs),
        .pre_de      (pre_de),
        .shift_en    (shift_en),
        .read_de     (read_de),
        .win_vs      (win_vs),
        .win_de      (win_de),
        .win_valid   (win_valid),
        .win_col     (win_col),
        .win_row     (win_row),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy),
        .err_len     (err_len),
        .err_short   (err_short)
    );

    always @(posedge clk) begin
        #1;
        if (frame_start) fs_cnt++;
        if (frame_done)  fd_cnt++;
        if (win_de)      wd_cnt++;
        if (win_valid) begin
            wv_col_q.push_back(win_col);
            wv_row_q.push_back(win_row);
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic vs, input logic de);
        @(negedge clk);
        pre_vs = vs;
        pre_de = de;
    endtask

    task automatic line(input int n);
        repeat (n) tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
    endtask

    int fs0, fd0, wd0, wv0;

    initial begin
        rst_n  = 1'b0;
        pre_vs = 1'b0;
        pre_de = 1'b0;
        repeat (3) @(negedge clk);
        chk1("rst_read_de", read_de, 1'b0);
        chk1("rst_win_vs", win_vs, 1'b0);
        chk1("rst_win_de", win_de, 1'b0);
        chk1("rst_win_valid", win_valid, 1'b0);
        chk1("rst_frame_start", frame_start, 1'b0);
        chk1("rst_frame_done", frame_done, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err_len", err_len, 1'b0);
        chk1("rst_err_short", err_short, 1'b0);
        chkn("rst_win_col", win_col, 12'd0);
        chkn("rst_win_row", win_row, 12'd0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        // pre_de without a frame is ignored
        tick(1'b0, 1'b1);
        #1 chk1("idle_shift_en", shift_en, 1'b0);
        tick(1'b0, 1'b0);
        chk1("idle_read_de", read_de, 1'b0);
        tick(1'b0, 1'b0);
        chk1("idle_win_de", win_de, 1'b0);

        // Clean 4x3 frame
        fs0 = fs_cnt; fd0 = fd_cnt; wd0 = wd_cnt; wv0 = wv_col_q.size();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk1("c_frame_start", frame_start, 1'b1);
        chk1("c_busy", busy, 1'b1);
        tick(1'b1, 1'b1);
        #1 chk1("c_shift_en", shift_en, 1'b1);
        tick(1'b1, 1'b1);
        chk1("c_read_de_lat1", read_de, 1'b1);
        chk1("c_win_de_lat1", win_de, 1'b0);
        tick(1'b1, 1'b1);
        chk1("c_win_de_lat2", win_de, 1'b1);
        chk1("c_win_vs_lat2", win_vs, 1'b1);
        chkn("c_win_col0", win_col, 12'd0);
        chkn("c_win_row0", win_row, 12'd0);
        chk1("c_win_valid0", win_valid, 1'b0);
        tick(1'b1, 1'b1);
        chkn("c_win_col1", win_col, 12'd1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        line(4);
        repeat (4) tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        #1 chk1("c_done_shift_en", shift_en, 1'b0);
        chk1("c_frame_done", frame_done, 1'b1);
        chk1("c_done_busy", busy, 1'b1);
        tick(1'b1, 1'b0);
        chk1("c_frame_done_pulse", frame_done, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk1("c_idle_busy", busy, 1'b0);
        chki("c_fs_count", fs_cnt - fs0, 1);
        chki("c_fd_count", fd_cnt - fd0, 1);
        chki("c_win_de_count", wd_cnt - wd0, 12);
        chki("c_win_valid_count", wv_col_q.size() - wv0, 2);
        if (wv_col_q.size() >= wv0 + 2) begin
            chkn("c_wv_col_a", wv_col_q[wv0], 12'd2);
            chkn("c_wv_col_b", wv_col_q[wv0+1], 12'd3);
            chkn("c_wv_row_a", wv_row_q[wv0], 12'd2);
            chkn("c_wv_row_b", wv_row_q[wv0+1], 12'd2);
        end
        chk1("c_err_len", err_len, 1'b0);
        chk1("c_err_short", err_short, 1'b0);

        // Short middle line
        wv0 = wv_col_q.size();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        line(4);
        line(3);
        chk1("s_err_len_set", err_len, ERR_EXP);
        line(4);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk1("s_err_len_hold", err_len, ERR_EXP);
        chk1("s_err_short", err_short, 1'b0);
        chki("s_win_valid_count", wv_col_q.size() - wv0, 2);
        if (wv_col_q.size() >= wv0 + 2) begin
            chkn("s_wv_col_a", wv_col_q[wv0], 12'd2);
            chkn("s_wv_col_b", wv_col_q[wv0+1], 12'd3);
        end

        // Next frame clears errors; truncate after 2 lines
        fd0 = fd_cnt;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk1("t_frame_start", frame_start, 1'b1);
        chk1("t_err_len_clr", err_len, 1'b0);
        line(4);
        line(4);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk1("t_frame_done", frame_done, 1'b1);
        chk1("t_err_short", err_short, ERR_EXP);
        chk1("t_busy", busy, 1'b0);
        tick(1'b0, 1'b0);
        chki("t_fd_count", fd_cnt - fd0, 1);

        // vs and de fall together on the last line: all rows counted, no truncation
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk1("l_err_short_clr", err_short, 1'b0);
        line(4);
        line(4);
        repeat (4) tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk1("l_frame_done", frame_done, 1'b1);
        chk1("l_err_short", err_short, 1'b0);
        chk1("l_err_len", err_len, 1'b0);
        chk1("l_busy", busy, 1'b0);

        // vs and de fall together on the second line: truncated
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        line(4);
        repeat (4) tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk1("m_frame_done", frame_done, 1'b1);
        chk1("m_err_short", err_short, ERR_EXP);
        chk1("m_err_len", err_len, 1'b0);

        // Reset mid-line with vs held high
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("r_busy", busy, 1'b0);
        chk1("r_read_de", read_de, 1'b0);
        chk1("r_win_de", win_de, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        rst_n = 1'b1;
        fs0 = fs_cnt;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        #1 chk1("r_shift_en", shift_en, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chki("r_no_frame_start", fs_cnt - fs0, 0);
        chk1("r_busy_idle", busy, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk1("r_frame_start", frame_start, 1'b1);
        chk1("r_busy_new", busy, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
